// File: rtl/sobel_stream_ctrl.sv
// Streaming 3x3 Sobel controller: builds a window from a pixel stream and emits |Gx|+|Gy|
// over valid/ready. Optional SOBEL_THRESHOLD_EN turns the result into a binary edge map.
module sobel_stream_ctrl #(
    parameter int PIXEL_WIDTH = 8,
    parameter int OUT_WIDTH   = 8,
    parameter int COUNT_WIDTH = 24
) (
    input  logic                   clk_i,
    input  logic                   nreset_i,
    input  logic                   start_i,
    input  logic                   clear_i,
    input  logic                   reload_i,
    input  logic [COUNT_WIDTH-1:0] num_windows_i,
`ifdef SOBEL_THRESHOLD_EN
    input  logic [OUT_WIDTH-1:0]   threshold_i,
`endif
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [PIXEL_WIDTH-1:0] in_px_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [OUT_WIDTH-1:0]   out_px_o,
    output logic                   busy_o,
    output logic                   done_o
);

    localparam int SW = PIXEL_WIDTH + 2;
    localparam int GW = PIXEL_WIDTH + 3;
    localparam int MW = PIXEL_WIDTH + 4;
    localparam int EW = (MW > OUT_WIDTH) ? MW : OUT_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM} state_t;

    state_t                        state_q, state_d;
    logic [3:0]                    cnt_q, cnt_d;
    logic [8:0][PIXEL_WIDTH-1:0]   win_q, win_d;
    logic [COUNT_WIDTH-1:0]        win_cnt_q, win_cnt_d;
    logic [COUNT_WIDTH-1:0]        num_win_q, num_win_d;
    logic                          pend_q, pend_d;
    logic                          fin_q, fin_d;
    logic                          out_valid_q, out_valid_d;
    logic [OUT_WIDTH-1:0]          out_px_q, out_px_d;
    logic                          done_q, done_d;
`ifdef SOBEL_THRESHOLD_EN
    logic [OUT_WIDTH-1:0]          thr_q, thr_d;
`endif

    logic                          acc, xfer, complete;
    logic [SW-1:0]                 gx_pos, gx_neg, gy_pos, gy_neg;
    logic signed [GW-1:0]          gx, gy;
    logic [GW-1:0]                 ax, ay;
    logic [MW-1:0]                 mag;
    logic [EW-1:0]                 mag_e, sat_e;
    logic [OUT_WIDTH-1:0]          f_val;

    // Window index: 0..2 = row0 (p00..p02), 3..5 = row1, 6..8 = row2.
    always_comb begin
        gx_pos = SW'(win_q[2]) + (SW'(win_q[5]) << 1) + SW'(win_q[8]);
        gx_neg = SW'(win_q[0]) + (SW'(win_q[3]) << 1) + SW'(win_q[6]);
        gy_pos = SW'(win_q[6]) + (SW'(win_q[7]) << 1) + SW'(win_q[8]);
        gy_neg = SW'(win_q[0]) + (SW'(win_q[1]) << 1) + SW'(win_q[2]);
        gx     = signed'(GW'(gx_pos)) - signed'(GW'(gx_neg));
        gy     = signed'(GW'(gy_pos)) - signed'(GW'(gy_neg));
        ax     = gx[GW-1] ? $unsigned(-gx) : $unsigned(gx);
        ay     = gy[GW-1] ? $unsigned(-gy) : $unsigned(gy);
        mag    = MW'(ax) + MW'(ay);
        mag_e  = EW'(mag);
        sat_e  = EW'({OUT_WIDTH{1'b1}});
`ifdef SOBEL_THRESHOLD_EN
        f_val  = (mag_e >= EW'(thr_q)) ? '1 : '0;
`else
        f_val  = (mag_e > sat_e) ? '1 : OUT_WIDTH'(mag_e);
`endif
    end

    assign in_ready_o  = (state_q != S_IDLE) && !pend_q && !fin_q;
    assign acc         = in_valid_i && in_ready_o;
    assign xfer        = pend_q && (!out_valid_q || out_ready_i);
    assign out_valid_o = out_valid_q;
    assign out_px_o    = out_px_q;
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = done_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        win_d       = win_q;
        win_cnt_d   = win_cnt_q;
        num_win_d   = num_win_q;
        pend_d      = pend_q;
        fin_d       = fin_q;
        out_valid_d = out_valid_q;
        out_px_d    = out_px_q;
        done_d      = 1'b0;
        complete    = 1'b0;
`ifdef SOBEL_THRESHOLD_EN
        thr_d       = thr_q;
`endif

        if (xfer) begin
            out_valid_d = 1'b1;
            out_px_d    = f_val;
            pend_d      = 1'b0;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d   = S_LOAD;
                    num_win_d = num_windows_i;
                    win_cnt_d = '0;
                    cnt_d     = '0;
                    fin_d     = 1'b0;
`ifdef SOBEL_THRESHOLD_EN
                    thr_d     = threshold_i;
`endif
                end
            end
            S_LOAD, S_STREAM: begin
                if (reload_i) begin
                    state_d = S_LOAD;
                    if (acc) begin
                        win_d[0] = in_px_i;
                        cnt_d    = 4'd1;
                    end else begin
                        cnt_d    = '0;
                    end
                end else if (acc) begin
                    if (state_q == S_LOAD) begin
                        win_d[cnt_q] = in_px_i;
                        if (cnt_q == 4'd8) begin
                            complete = 1'b1;
                            state_d  = S_STREAM;
                            cnt_d    = '0;
                        end else begin
                            cnt_d    = cnt_q + 4'd1;
                        end
                    end else begin
                        // First pixel of a group scrolls the window up one row.
                        case (cnt_q)
                            4'd0: begin
                                win_d[5:0] = win_q[8:3];
                                win_d[6]   = in_px_i;
                                cnt_d      = 4'd1;
                            end
                            4'd1: begin
                                win_d[7] = in_px_i;
                                cnt_d    = 4'd2;
                            end
                            default: begin
                                win_d[8] = in_px_i;
                                complete = 1'b1;
                                cnt_d    = '0;
                            end
                        endcase
                    end
                end

                if (complete) begin
                    pend_d    = 1'b1;
                    win_cnt_d = win_cnt_q + 1'b1;
                    if ((num_win_q != '0) && (win_cnt_d == num_win_q)) fin_d = 1'b1;
                end

                if (fin_q && !pend_q && out_valid_q && out_ready_i) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    fin_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (clear_i) begin
            state_d     = S_IDLE;
            pend_d      = 1'b0;
            fin_d       = 1'b0;
            out_valid_d = 1'b0;
            cnt_d       = '0;
            win_cnt_d   = '0;
            done_d      = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            win_q       <= '0;
            win_cnt_q   <= '0;
            num_win_q   <= '0;
            pend_q      <= 1'b0;
            fin_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_px_q    <= '0;
            done_q      <= 1'b0;
`ifdef SOBEL_THRESHOLD_EN
            thr_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            win_q       <= win_d;
            win_cnt_q   <= win_cnt_d;
            num_win_q   <= num_win_d;
            pend_q      <= pend_d;
            fin_q       <= fin_d;
            out_valid_q <= out_valid_d;
            out_px_q    <= out_px_d;
            done_q      <= done_d;
`ifdef SOBEL_THRESHOLD_EN
            thr_q       <= thr_d;
`endif
        end
    end

endmodule

// File: tb/tb_sobel_stream_ctrl.sv
// Directed bench for sobel_stream_ctrl: load/stream windows, backpressure, reload, clear,
// async reset and (with SOBEL_THRESHOLD_EN) the threshold output mode.
module tb_sobel_stream_ctrl;

    logic        clk_i = 1'b0;
    logic        nreset_i = 1'b0;
    logic        start_i = 1'b0;
    logic        clear_i = 1'b0;
    logic        reload_i = 1'b0;
    logic [23:0] num_windows_i = '0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [7:0]  in_px_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [7:0]  out_px_o;
    logic        busy_o;
    logic        done_o;
`ifdef SOBEL_THRESHOLD_EN
    logic [7:0]  threshold_i = 8'd100;
`endif

    int n_chk = 0;
    int n_fail = 0;

    sobel_stream_ctrl dut (
        .clk_i(clk_i), .nreset_i(nreset_i), .start_i(start_i), .clear_i(clear_i),
        .reload_i(reload_i), .num_windows_i(num_windows_i),
`ifdef SOBEL_THRESHOLD_EN
        .threshold_i(threshold_i),
`endif
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_px_i(in_px_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_px_o(out_px_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Expected output for a hand-computed magnitude m (threshold fixed at 100).
    function automatic int fexp(input int m);
`ifdef SOBEL_THRESHOLD_EN
        return (m >= 100) ? 255 : 0;
`else
        return (m > 255) ? 255 : m;
`endif
    endfunction

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int px);
        int t;
        in_valid_i = 1'b1;
        in_px_i    = 8'(px);
        t = 0;
        while (!in_ready_o && t < 50) begin
            tick;
            t++;
        end
        if (!in_ready_o) chk("push_timeout", 0, 1);
        tick;
        in_valid_i = 1'b0;
    endtask

    task automatic start_run(input int n);
        num_windows_i = 24'(n);
        start_i = 1'b1;
        tick;
        start_i = 1'b0;
    endtask

    task automatic pulse_reload;
        reload_i = 1'b1;
        tick;
        reload_i = 1'b0;
    endtask

    task automatic pulse_clear;
        clear_i = 1'b1;
        tick;
        clear_i = 1'b0;
    endtask

    initial begin
        // Reset state
        tick; tick;
        chk("rst_in_ready", int'(in_ready_o), 0);
        chk("rst_out_valid", int'(out_valid_o), 0);
        chk("rst_out_px", int'(out_px_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_done", int'(done_o), 0);
        nreset_i = 1'b1;
        tick;

        // Ramp: flat zero window, then a vertical edge after reload (M=1020 saturates)
        out_ready_i = 1'b1;
        start_run(2);
        chk("ramp_busy", int'(busy_o), 1);
        chk("ramp_in_ready", int'(in_ready_o), 1);
        for (int i = 0; i < 9; i++) push(0);
        chk("ramp_lat_k", int'(out_valid_o), 0);
        chk("ramp_pend_rdy", int'(in_ready_o), 0);
        tick;
        chk("ramp_valid1", int'(out_valid_o), 1);
        chk("ramp_px1", int'(out_px_o), fexp(0));
        pulse_reload;
        chk("ramp_reload_vld", int'(out_valid_o), 0);
        for (int r = 0; r < 3; r++) begin
            push(0); push(0); push(255);
        end
        chk("ramp_final_rdy", int'(in_ready_o), 0);
        tick;
        chk("ramp_valid2", int'(out_valid_o), 1);
        chk("ramp_px2", int'(out_px_o), fexp(1020));
        chk("ramp_done_early", int'(done_o), 0);
        tick;
        chk("ramp_done", int'(done_o), 1);
        chk("ramp_busy_end", int'(busy_o), 0);
        tick;
        chk("ramp_done_pulse", int'(done_o), 0);

        // Streaming: rows shift up on each 3-pixel group
        start_run(3);
        for (int i = 0; i < 9; i++) push(10);
        chk("strm_lat_k1", int'(out_valid_o), 0);
        tick;
        chk("strm_px1", int'(out_px_o), fexp(0));
        push(10); push(20); push(30);
        chk("strm_lat_k2", int'(out_valid_o), 0);
        tick;
        chk("strm_valid2", int'(out_valid_o), 1);
        chk("strm_px2", int'(out_px_o), fexp(60));
        push(10); push(20); push(30);
        chk("strm_lat_k3", int'(out_valid_o), 0);
        tick;
        chk("strm_px3", int'(out_px_o), fexp(100));
        tick;
        chk("strm_done", int'(done_o), 1);
        chk("strm_busy_end", int'(busy_o), 0);

        // Backpressure in free-running mode
        out_ready_i = 1'b0;
        start_run(0);
        for (int i = 0; i < 8; i++) push(0);
        push(50);
        tick;
        chk("bp_valid1", int'(out_valid_o), 1);
        chk("bp_px1", int'(out_px_o), fexp(100));
        push(0); push(0); push(7);
        for (int i = 0; i < 8; i++) tick;
        chk("bp_hold_valid", int'(out_valid_o), 1);
        chk("bp_hold_px", int'(out_px_o), fexp(100));
        chk("bp_hold_rdy", int'(in_ready_o), 0);
        out_ready_i = 1'b1;
        tick;
        chk("bp_valid2", int'(out_valid_o), 1);
        chk("bp_px2", int'(out_px_o), fexp(114));
        tick;
        chk("bp_drained", int'(out_valid_o), 0);
        chk("bp_rdy_back", int'(in_ready_o), 1);

        // Clear with a result both pending and presented
        out_ready_i = 1'b0;
        push(0); push(1); push(0);
        tick;
        chk("clr_px3", int'(out_px_o), fexp(112));
        push(0); push(0); push(0);
        chk("clr_pend_rdy", int'(in_ready_o), 0);
        pulse_clear;
        chk("clr_busy", int'(busy_o), 0);
        chk("clr_valid", int'(out_valid_o), 0);
        chk("clr_rdy", int'(in_ready_o), 0);
        chk("clr_done", int'(done_o), 0);
        tick;
        chk("clr_done_next", int'(done_o), 0);

        // Reload mid-STREAM with a simultaneous accept: that pixel becomes p00
        out_ready_i = 1'b1;
        start_run(0);
        for (int i = 0; i < 9; i++) push(0);
        tick;
        chk("rld_px0", int'(out_px_o), fexp(0));
        push(9);
        reload_i   = 1'b1;
        in_valid_i = 1'b1;
        in_px_i    = 8'd7;
        chk("rld_accept_rdy", int'(in_ready_o), 1);
        tick;
        reload_i   = 1'b0;
        in_valid_i = 1'b0;
        for (int i = 0; i < 7; i++) push(0);
        tick; tick;
        chk("rld_no_early", int'(out_valid_o), 0);
        push(0);
        tick;
        chk("rld_valid", int'(out_valid_o), 1);
        chk("rld_px", int'(out_px_o), fexp(14));
        pulse_clear;

        // Async reset mid-LOAD with a result on the output
        out_ready_i = 1'b0;
        start_run(0);
        for (int i = 0; i < 9; i++) push(0);
        tick;
        pulse_reload;
        push(3); push(4);
        #2;
        nreset_i = 1'b0;
        #1;
        chk("arst_valid", int'(out_valid_o), 0);
        chk("arst_busy", int'(busy_o), 0);
        chk("arst_rdy", int'(in_ready_o), 0);
        chk("arst_px", int'(out_px_o), 0);
        tick;
        nreset_i = 1'b1;
        tick;

        // Threshold boundary: M=98 and M=100 against threshold 100
        out_ready_i = 1'b1;
        start_run(2);
        for (int i = 0; i < 8; i++) push(0);
        push(49);
        tick;
        chk("thr_px98", int'(out_px_o), fexp(98));
        pulse_reload;
        for (int i = 0; i < 8; i++) push(0);
        push(50);
        tick;
        chk("thr_px100", int'(out_px_o), fexp(100));
        tick;
        chk("thr_done", int'(done_o), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
